psg_multi: RTL and testbench

Parametrised AY-3-8910-style programmable sound generator for the ts2068 audio path. It provides 1–8 square-wave tone channels, one shared envelope generator and one shared 17-bit noise LFSR. Each channel has a -3 dB/step logarithmic volume DAC and can be panned left/right. The block sits on the CPU I/O bus using the bdir/bc1 protocol and outputs per-channel samples plus summed stereo samples to the audio mixer.

---
 rtl/psg_multi.sv | 259 +++++++++++++++++++++++++
 tb/tb_psg_multi.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/psg_multi.sv
// psg_multi: AY-3-8910-style PSG, 1..8 tone channels, shared envelope and noise.
// Define PSG_STEREO_EN to implement per-channel pan registers (0x20+i).
module psg_multi #(
  parameter  int CHANNELS = 3,
  parameter  int DACW     = 12,
  localparam int OUTW     = DACW + 3
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     ce,
  input  logic                     sel,
  input  logic                     bdir,
  input  logic                     bc1,
  input  logic [7:0]               d,
  output logic [7:0]               q,
  output logic [CHANNELS*DACW-1:0] ch_out,
  output logic [OUTW-1:0]          left,
  output logic [OUTW-1:0]          right
);

`ifdef PSG_STEREO_EN
  localparam bit STEREO = 1'b1;
`else
  localparam bit STEREO = 1'b0;
`endif

  localparam logic [7:0] CHM = 8'((16'd1 << CHANNELS) - 16'd1);

  // -3 dB per step; entry 0 is silence
  function automatic logic [16*DACW-1:0] dac_tab();
    logic [16*DACW-1:0] t;
    real full, v;
    full = real'((64'd1 << DACW) - 64'd1);
    t = '0;
    for (int n = 1; n < 16; n++) begin
      v = full * (10.0 ** (-3.0 * real'(15 - n) / 20.0));
      t[n*DACW +: DACW] = DACW'($rtoi(v + 0.5));
    end
    return t;
  endfunction

  localparam logic [16*DACW-1:0] DAC = dac_tab();

  function automatic logic chv(input logic [2:0] c);
    return int'(c) < CHANNELS;
  endfunction

  logic [5:0]  addr_q;
  logic [11:0] per_q [8];
  logic [4:0]  vol_q [8];
  logic [1:0]  pan_q [8];
  logic [4:0]  nper_q;
  logic [7:0]  tdis_q, ndis_q;
  logic [15:0] eper_q;
  logic [3:0]  shape_q;
  logic        restart_q;

  logic [3:0] cc_q;
  logic       stb;

  always_ff @(negedge clock or negedge reset) begin
    if (!reset) cc_q <= '0;
    else if (ce) cc_q <= cc_q + 4'd1;
  end

  assign stb = sel ? &cc_q[2:0] : &cc_q;

  logic       lat, wr;
  logic [2:0] ci, cv;
  logic a_per, a_vol, a_np, a_td, a_nd;
  logic a_el, a_eh, a_sh, a_pan;

  assign lat   = ce & bdir & bc1 & (d[7:6] == 2'b00);
  assign wr    = ce & bdir & ~bc1;
  assign ci    = addr_q[3:1];
  assign cv    = addr_q[2:0];
  assign a_per = (addr_q[5:4] == 2'b00) && chv(ci);
  assign a_vol = (addr_q[5:3] == 3'b010) && chv(cv);
  assign a_np  = addr_q == 6'h18;
  assign a_td  = addr_q == 6'h19;
  assign a_nd  = addr_q == 6'h1A;
  assign a_el  = addr_q == 6'h1B;
  assign a_eh  = addr_q == 6'h1C;
  assign a_sh  = addr_q == 6'h1D;
  assign a_pan = STEREO && (addr_q[5:3] == 3'b100) && chv(cv);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      addr_q    <= '0;
      nper_q    <= '0;
      tdis_q    <= '0;
      ndis_q    <= '0;
      eper_q    <= '0;
      shape_q   <= '0;
      restart_q <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        per_q[i] <= '0;
        vol_q[i] <= '0;
        pan_q[i] <= 2'b11;
      end
    end else if (ce) begin
      restart_q <= wr & a_sh;
      if (lat) addr_q <= d[5:0];
      if (wr) begin
        unique case (1'b1)
          a_per: begin
            if (addr_q[0]) per_q[ci][11:8] <= d[3:0];
            else per_q[ci][7:0] <= d;
          end
          a_vol:   vol_q[cv] <= d[4:0];
          a_np:    nper_q <= d[4:0];
          a_td:    tdis_q <= d & CHM;
          a_nd:    ndis_q <= d & CHM;
          a_el:    eper_q[7:0] <= d;
          a_eh:    eper_q[15:8] <= d;
          a_sh:    shape_q <= d[3:0];
          a_pan:   pan_q[cv] <= d[1:0];
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    q = '0;
    unique case (1'b1)
      a_per: q = addr_q[0] ? {4'h0, per_q[ci][11:8]} : per_q[ci][7:0];
      a_vol: q = {3'b000, vol_q[cv]};
      a_np:  q = {3'b000, nper_q};
      a_td:  q = tdis_q | ~CHM;
      a_nd:  q = ndis_q | ~CHM;
      a_el:  q = eper_q[7:0];
      a_eh:  q = eper_q[15:8];
      a_sh:  q = {4'h0, shape_q};
      a_pan: q = {6'b0, pan_q[cv]};
      default: q = '0;
    endcase
  end

  logic [11:0]         tcnt_q [CHANNELS];
  logic [CHANNELS-1:0] tff_q;
  logic [4:0]          ncnt_q;
  logic                nff_q, nrise_q;
  logic [16:0]         lfsr_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < CHANNELS; i++) tcnt_q[i] <= 12'd1;
      tff_q   <= '1;
      ncnt_q  <= 5'd1;
      nff_q   <= 1'b1;
      nrise_q <= 1'b0;
      lfsr_q  <= 17'h10000;
    end else if (ce && stb) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (tcnt_q[i] >= per_q[i]) begin
          tcnt_q[i] <= 12'd1;
          tff_q[i]  <= ~tff_q[i];
        end else begin
          tcnt_q[i] <= tcnt_q[i] + 12'd1;
        end
      end
      nrise_q <= 1'b0;
      if (ncnt_q >= nper_q) begin
        ncnt_q  <= 5'd1;
        nff_q   <= ~nff_q;
        nrise_q <= ~nff_q;
      end else begin
        ncnt_q <= ncnt_q + 5'd1;
      end
      if (nrise_q) lfsr_q <= {lfsr_q[3] ^ lfsr_q[0], lfsr_q[16:1]};
    end
  end

  logic [15:0] ecnt_q;
  logic        eff_q, up_q, ehold_q, ezero_q;
  logic [3:0]  step_q, env_lvl;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ecnt_q  <= 16'd1;
      eff_q   <= 1'b0;
      step_q  <= '0;
      up_q    <= 1'b0;
      ehold_q <= 1'b0;
      ezero_q <= 1'b0;
    end else if (ce) begin
      if (restart_q) begin
        ecnt_q  <= 16'd1;
        eff_q   <= 1'b0;
        step_q  <= '0;
        up_q    <= shape_q[2];
        ehold_q <= 1'b0;
        ezero_q <= 1'b0;
      end else if (stb) begin
        if (ecnt_q >= eper_q) begin
          ecnt_q <= 16'd1;
          eff_q  <= ~eff_q;
          // one step per full cycle of the envelope divider
          if (eff_q && !ehold_q) begin
            if (step_q != 4'hF) begin
              step_q <= step_q + 4'd1;
            end else if (!shape_q[3]) begin
              ehold_q <= 1'b1;
              ezero_q <= 1'b1;
            end else begin
              if (shape_q[1]) up_q <= ~up_q;
              if (shape_q[0]) ehold_q <= 1'b1;
              else step_q <= '0;
            end
          end
        end else begin
          ecnt_q <= ecnt_q + 16'd1;
        end
      end
    end
  end

  assign env_lvl = ezero_q ? 4'h0 : (up_q ? step_q : ~step_q);

  logic [DACW-1:0] samp [CHANNELS];
  logic [OUTW-1:0] sum_l, sum_r;
  logic [3:0]      lvl;
  logic            gate;

  always_comb begin
    sum_l = '0;
    sum_r = '0;
    lvl   = '0;
    gate  = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      lvl  = vol_q[i][4] ? env_lvl : vol_q[i][3:0];
      gate = (tdis_q[i] | tff_q[i]) & (ndis_q[i] | lfsr_q[0]);
      samp[i] = gate ? DAC[int'(lvl)*DACW +: DACW] : '0;
      if (pan_q[i][0] || !STEREO) sum_l = sum_l + OUTW'(samp[i]);
      if (pan_q[i][1] || !STEREO) sum_r = sum_r + OUTW'(samp[i]);
    end
  end

  logic [CHANNELS*DACW-1:0] ch_q;
  logic [OUTW-1:0]          l_q, r_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ch_q <= '0;
      l_q  <= '0;
      r_q  <= '0;
    end else if (ce) begin
      for (int i = 0; i < CHANNELS; i++) ch_q[i*DACW +: DACW] <= samp[i];
      l_q <= sum_l;
      r_q <= sum_r;
    end
  end

  assign ch_out = ch_q;
  assign left   = l_q;
  assign right  = r_q;

endmodule

// File: tb/tb_psg_multi.sv
// tb_psg_multi: directed bench for psg_multi (CHANNELS=3, DACW=12).
// Expectations follow the pan build selected by PSG_STEREO_EN.
module tb_psg_multi;
  localparam int CH = 3;
  localparam int DW = 12;
  localparam int OW = DW + 3;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic           ce = 1'b1;
  logic           sel = 1'b1;
  logic           bdir = 1'b0;
  logic           bc1 = 1'b0;
  logic [7:0]     d = '0;
  logic [7:0]     q;
  logic [CH*DW-1:0] ch_out;
  logic [OW-1:0]  left, right;

  int checks = 0;
  int errors = 0;

  psg_multi #(.CHANNELS(CH), .DACW(DW)) dut (
    .clock (clock),
    .reset (reset),
    .ce    (ce),
    .sel   (sel),
    .bdir  (bdir),
    .bc1   (bc1),
    .d     (d),
    .q     (q),
    .ch_out(ch_out),
    .left  (left),
    .right (right)
  );

  always #5 clock = ~clock;

`ifdef PSG_STEREO_EN
  localparam logic [7:0]    PAN_RST = 8'h03;
  localparam logic [7:0]    PAN_RD1 = 8'h01;
  localparam logic [OW-1:0] R_PAN   = 15'h1FFE;
`else
  localparam logic [7:0]    PAN_RST = 8'h00;
  localparam logic [7:0]    PAN_RD1 = 8'h00;
  localparam logic [OW-1:0] R_PAN   = 15'h2FFD;
`endif

  task automatic wr(input logic [7:0] a, input logic [7:0] v);
    @(negedge clock); bdir = 1'b1; bc1 = 1'b1; d = a;
    @(negedge clock); bdir = 1'b1; bc1 = 1'b0; d = v;
    @(negedge clock); bdir = 1'b0; bc1 = 1'b0; d = '0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [7:0] v);
    @(negedge clock); bdir = 1'b1; bc1 = 1'b1; d = a;
    @(negedge clock); bdir = 1'b0; bc1 = 1'b1; d = '0;
    #1 v = q;
    bc1 = 1'b0;
  endtask

  task automatic wait_change(input int bound, output int n,
                             output logic [11:0] v);
    logic [11:0] p;
    p = ch_out[11:0];
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (ch_out[11:0] === p && n < bound);
    v = ch_out[11:0];
  endtask

  task automatic test_reset;
    logic [7:0] v;
    #3 reset = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if (ch_out !== '0) begin
      errors++; $display("FAIL reset_ch_out got %h want 0", ch_out);
    end
    checks++;
    if (left !== '0 || right !== '0) begin
      errors++; $display("FAIL reset_lr got %h/%h want 0/0", left, right);
    end
    checks++;
    if (q !== 8'h00) begin
      errors++; $display("FAIL reset_q got %h want 00", q);
    end
    reset = 1'b1;
    rd(8'h20, v);
    checks++;
    if (v !== PAN_RST) begin
      errors++; $display("FAIL reset_pan got %h want %h", v, PAN_RST);
    end
  endtask

  task automatic test_tone;
    int n;
    logic [11:0] v0, v1;
    wr(8'h00, 8'h02);
    wr(8'h01, 8'h00);
    wr(8'h10, 8'h0F);
    wr(8'h19, 8'hFE);
    wr(8'h1A, 8'hFF);
    wait_change(40, n, v0);
    checks++;
    if (n >= 40 || (v0 !== 12'hFFF && v0 !== 12'h000)) begin
      errors++; $display("FAIL tone_first got %h after %0d want 000/FFF", v0, n);
    end
    wait_change(40, n, v1);
    checks++;
    if (n !== 16) begin
      errors++; $display("FAIL tone_period8 got %0d want 16", n);
    end
    checks++;
    if (v1 !== (v0 ^ 12'hFFF)) begin
      errors++; $display("FAIL tone_alt got %h want %h", v1, v0 ^ 12'hFFF);
    end
    sel = 1'b0;
    wait_change(80, n, v0);
    wait_change(80, n, v1);
    checks++;
    if (n !== 32) begin
      errors++; $display("FAIL tone_period16 got %0d want 32", n);
    end
    sel = 1'b1;
  endtask

  task automatic test_reset_mid;
    logic [7:0] v;
    @(negedge clock);
    #2 reset = 1'b0;
    #1;
    checks++;
    if (ch_out !== '0 || left !== '0 || right !== '0) begin
      errors++;
      $display("FAIL midreset_out got %h %h %h want 0", ch_out, left, right);
    end
    checks++;
    if (q !== 8'h00) begin
      errors++; $display("FAIL midreset_q got %h want 00", q);
    end
    @(negedge clock);
    reset = 1'b1;
    rd(8'h10, v);
    checks++;
    if (v !== 8'h00) begin
      errors++; $display("FAIL midreset_vol got %h want 00", v);
    end
  endtask

  task automatic test_fixed;
    wr(8'h19, 8'hFF);
    wr(8'h1A, 8'hFF);
    wr(8'h10, 8'h08);
    repeat (3) @(negedge clock);
    checks++;
    if (ch_out[11:0] !== 12'h16D) begin
      errors++; $display("FAIL fixed_lvl8 got %h want 16D", ch_out[11:0]);
    end
    repeat (50) @(negedge clock);
    checks++;
    if (ch_out[11:0] !== 12'h16D || left !== 15'h016D) begin
      errors++;
      $display("FAIL fixed_hold got %h/%h want 16D/016D", ch_out[11:0], left);
    end
  endtask

  task automatic test_ce_hold;
    logic [7:0] v;
    ce = 1'b0;
    wr(8'h10, 8'h0F);
    ce = 1'b1;
    rd(8'h10, v);
    checks++;
    if (v !== 8'h08) begin
      errors++; $display("FAIL ce_hold got %h want 08", v);
    end
  endtask

  task automatic test_sum;
    logic [7:0] v;
    wr(8'h10, 8'h0F);
    wr(8'h11, 8'h0F);
    wr(8'h12, 8'h0F);
    repeat (3) @(negedge clock);
    checks++;
    if (ch_out !== 36'hFFF_FFF_FFF) begin
      errors++; $display("FAIL sum_ch got %h want FFFFFFFFF", ch_out);
    end
    checks++;
    if (left !== 15'h2FFD || right !== 15'h2FFD) begin
      errors++; $display("FAIL sum_lr got %h/%h want 2FFD/2FFD", left, right);
    end
    wr(8'h21, 8'h01);
    repeat (3) @(negedge clock);
    checks++;
    if (left !== 15'h2FFD || right !== R_PAN) begin
      errors++;
      $display("FAIL sum_pan got %h/%h want 2FFD/%h", left, right, R_PAN);
    end
    rd(8'h21, v);
    checks++;
    if (v !== PAN_RD1) begin
      errors++; $display("FAIL pan_read got %h want %h", v, PAN_RD1);
    end
    wr(8'h21, 8'h03);
  endtask

  task automatic test_bounds;
    logic [7:0] v;
    wr(8'h06, 8'h55);
    rd(8'h06, v);
    checks++;
    if (v !== 8'h00) begin
      errors++; $display("FAIL ch3_per got %h want 00", v);
    end
    wr(8'h13, 8'h0F);
    rd(8'h13, v);
    checks++;
    if (v !== 8'h00) begin
      errors++; $display("FAIL ch3_vol got %h want 00", v);
    end
    repeat (3) @(negedge clock);
    checks++;
    if (ch_out !== 36'hFFF_FFF_FFF || left !== 15'h2FFD || right !== 15'h2FFD) begin
      errors++;
      $display("FAIL ch3_out got %h %h %h want unchanged", ch_out, left, right);
    end
    rd(8'h3F, v);
    checks++;
    if (v !== 8'h00) begin
      errors++; $display("FAIL unmapped got %h want 00", v);
    end
  endtask

  task automatic test_regs;
    logic [7:0] v;
    wr(8'h03, 8'hFF);
    rd(8'h03, v);
    checks++;
    if (v !== 8'h0F) begin
      errors++; $display("FAIL per_hi got %h want 0F", v);
    end
    wr(8'h19, 8'hFE);
    rd(8'h19, v);
    checks++;
    if (v !== 8'hFE) begin
      errors++; $display("FAIL mask_read got %h want FE", v);
    end
    wr(8'h19, 8'hFF);
  endtask

  task automatic test_envelope;
    int n;
    logic [11:0] v;
    logic [7:0]  r;
    wr(8'h10, 8'h1F);
    wr(8'h1B, 8'h01);
    wr(8'h1C, 8'h00);
    wr(8'h1D, 8'h0D);
    repeat (3) @(negedge clock);
    checks++;
    if (ch_out[11:0] !== 12'h000) begin
      errors++; $display("FAIL env_start got %h want 000", ch_out[11:0]);
    end
    wait_change(40, n, v);
    checks++;
    if (v !== 12'h021) begin
      errors++; $display("FAIL env_step1 got %h want 021", v);
    end
    wait_change(40, n, v);
    checks++;
    if (n !== 16 || v !== 12'h02E) begin
      errors++; $display("FAIL env_step2 got %h after %0d want 02E after 16", v, n);
    end
    repeat (300) @(negedge clock);
    checks++;
    if (ch_out[11:0] !== 12'hFFF) begin
      errors++; $display("FAIL env_hold got %h want FFF", ch_out[11:0]);
    end
    rd(8'h1D, r);
    checks++;
    if (r !== 8'h0D) begin
      errors++; $display("FAIL env_shape got %h want 0D", r);
    end
    wr(8'h1D, 8'h0D);
    repeat (3) @(negedge clock);
    checks++;
    if (ch_out[11:0] !== 12'h000) begin
      errors++; $display("FAIL env_restart got %h want 000", ch_out[11:0]);
    end
  endtask

  initial begin
    test_reset;
    test_tone;
    test_reset_mid;
    test_fixed;
    test_ce_hold;
    test_sum;
    test_bounds;
    test_regs;
    test_envelope;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
